cen_mean_unit: RTL and testbench

- Parametrised centering-mean engine for the FastICA preprocessing path. Generalises the fixed 4-channel divide-by-128 stage.
- Accumulates N = 2^LOG2_N samples per channel through a valid/ready stream, then divides by N with a shift.
- Presents NCH channel means to the centering subtractor with a held output handshake.

---
 rtl/cen_mean_unit.sv | 130 +++++++++++++
 tb/tb_cen_mean_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cen_mean_unit.sv
// cen_mean_unit -- centering-mean engine for the FastICA preprocessing path.
//
// Accumulates N = 2^LOG2_N samples on each of NCH channels through a
// valid/ready stream, divides each sum by N with a shift, and then holds the
// per-channel means until the centering subtractor takes them.
//
// Optional feature (compile-time macro CEN_ROUND_EN):
//   defined   - round-half-up division, saturating at 2^DATA_W-1
//   undefined - plain truncating shift
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      one-cycle batch request, honoured only in IDLE
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts a sample this cycle (high in ACC)
//   in_data    packed samples, channel k at [k*DATA_W +: DATA_W]
//   out_valid  out_mean is valid (high in DONE)
//   out_ready  consumer takes out_mean
//   out_mean   packed per-channel means, same packing as in_data
//   busy       high in every state except IDLE
//   sample_cnt samples accepted in the current batch
//
// state | meaning
// IDLE  | waiting for start; out_mean holds the previous result
// ACC   | accepting samples into the accumulators
// DIV   | one cycle: shift the sums into out_mean
// DONE  | out_valid held until out_ready
module cen_mean_unit #(
  parameter int NCH    = 4,
  parameter int DATA_W = 16,
  parameter int LOG2_N = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*DATA_W-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*DATA_W-1:0]   out_mean,
  output logic                    busy,
  output logic [LOG2_N:0]         sample_cnt
);

  localparam int ACC_W = DATA_W + LOG2_N;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [LOG2_N:0] N_CNT   = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [LOG2_N:0] CNT_ONE = {{LOG2_N{1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [ACC_W-1:0]       acc [NCH];
  logic [NCH*DATA_W-1:0]  mean_next;
  logic                   accept;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

`ifdef CEN_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N - 1);

  logic [ACC_W:0] rnd_sum [NCH];
  logic [ACC_W:0] rnd_q   [NCH];

  always_comb begin
    mean_next = '0;
    for (int k = 0; k < NCH; k++) begin
      rnd_sum[k] = {1'b0, acc[k]} + HALF;
      rnd_q[k]   = rnd_sum[k] >> LOG2_N;
      // Any bit above DATA_W set means the rounded mean does not fit.
      if (|rnd_q[k][ACC_W:DATA_W])
        mean_next[k*DATA_W +: DATA_W] = '1;
      else
        mean_next[k*DATA_W +: DATA_W] = rnd_q[k][DATA_W-1:0];
    end
  end
`else
  always_comb begin
    mean_next = '0;
    for (int k = 0; k < NCH; k++) begin
      // Taking the top DATA_W bits of the sum is the divide by N.
      mean_next[k*DATA_W +: DATA_W] = acc[k][ACC_W-1:LOG2_N];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      out_mean   <= '0;
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sample_cnt <= '0;
            for (int k = 0; k < NCH; k++) acc[k] <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            for (int k = 0; k < NCH; k++)
              acc[k] <= acc[k] + ACC_W'(in_data[k*DATA_W +: DATA_W]);
            sample_cnt <= sample_cnt + CNT_ONE;
            if (sample_cnt + CNT_ONE == N_CNT) state <= DIV;
          end
        end
        DIV: begin
          out_mean <= mean_next;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cen_mean_unit.sv
module tb_cen_mean_unit;

  localparam int NCH    = 4;
  localparam int DATA_W = 16;
  localparam int LOG2_N = 7;
  localparam int N      = 1 << LOG2_N;

`ifdef CEN_ROUND_EN
  localparam logic [15:0] RAMP_MEAN = 16'd64;
`else
  localparam logic [15:0] RAMP_MEAN = 16'd63;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [63:0] in_data, out_mean;
  logic [7:0]  sample_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q [$];
  logic        prev_ov;

  cen_mean_unit #(.NCH(NCH), .DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mean(out_mean),
    .busy(busy), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the scoreboard head on each new out_valid assertion.
  always @(negedge clk) begin
    if (rst) prev_ov <= 1'b0;
    else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output actual=%0h required=none", out_mean);
        end else begin
          chk("mon_out_mean", out_mean, exp_q.pop_front());
          chk("mon_sample_cnt", 64'(sample_cnt), 64'(N));
        end
      end
      prev_ov <= out_valid;
    end
  end

  // kind: 0 constant, 1 ramp, 2 bubbles, 3 start pulse at sample 60
  task automatic do_batch(input int kind, input logic [63:0] val, input logic [63:0] exp);
    exp_q.push_back(exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_busy", 64'(busy), 64'd1);
    chk("acc_in_ready", 64'(in_ready), 64'd1);
    chk("acc_cnt_clear", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < N; i++) begin
      if (kind == 2 && (i % 2) == 1) begin
        in_valid = 1'b0;
        tick();
        tick();
        if (i == 1) chk("bubble_cnt", 64'(sample_cnt), 64'd1);
      end
      in_valid = 1'b1;
      in_data  = (kind == 1) ? {16'd1, 16'd0, 16'(127 - i), 16'(i)} : val;
      if (kind == 3 && i == 60) start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (kind == 3 && i == 60) begin
        chk("start_ignored_cnt", 64'(sample_cnt), 64'd61);
        chk("start_ignored_rdy", 64'(in_ready), 64'd1);
      end
    end
    chk("div_in_ready", 64'(in_ready), 64'd0);
    chk("div_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("done_out_valid", 64'(out_valid), 64'd1);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    chk("done_cnt", 64'(sample_cnt), 64'(N));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mean", out_mean, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);

    // Constant input, including a full-scale channel.
    do_batch(0, {16'd65535, 16'd300, 16'd200, 16'd100},
                {16'd65535, 16'd300, 16'd200, 16'd100});
    handshake();
    chk("idle_holds_mean", out_mean, {16'd65535, 16'd300, 16'd200, 16'd100});

    // Ramp: sum 8128 on ch0 and ch1, exercises rounding vs truncation.
    do_batch(1, '0, {16'd1, 16'd0, RAMP_MEAN, RAMP_MEAN});
    handshake();

    // All full-scale: must not wrap in either build.
    do_batch(0, '1, '1);
    handshake();

    // Bubbles on the input stream.
    do_batch(2, {4{16'd7}}, {4{16'd7}});

    // Backpressure with a start pulse inside DONE.
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      tick();
      start = 1'b0;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_mean", out_mean, {4{16'd7}});
    end
    chk("bp_cnt", 64'(sample_cnt), 64'(N));
    handshake();

    // Reset in the middle of accumulation.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = {4{16'd1000}};
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_cnt", 64'(sample_cnt), 64'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_mean", out_mean, 64'd0);
    chk("mid_rst_cnt", 64'(sample_cnt), 64'd0);
    do_batch(0, {4{16'd5}}, {4{16'd5}});
    handshake();

    // start asserted during ACC.
    do_batch(3, {16'd45, 16'd44, 16'd43, 16'd42}, {16'd45, 16'd44, 16'd43, 16'd42});
    held = out_mean;
    handshake();
    chk("idle_no_restart", 64'(busy), 64'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
